alu_mc: RTL and testbench

Multi-cycle, width-parametrised integer ALU for the next-generation datapath. It adds iterative unsigned multiply and divide to the single-cycle add/sub/logic operations, behind a start/done handshake. The datapath stalls on `busy`. Results and NZCV flags are registered and held stable until the next completed operation.

---
 rtl/alu_mc.sv | 174 +++++++++++++++++
 tb/tb_alu_mc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle integer ALU: single-cycle add/sub/logic, iterative mul and udiv.
// Define ALU_MC_DIV_EN to build the restoring divider and DIV state; otherwise opcode 110 is reserved.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Remainder,
    output logic [3:0]       ALUFlags
);

    localparam int CW = $clog2(WIDTH);

`ifdef ALU_MC_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

    state_t             state, state_nxt;
    logic               ready, accept, is_mul, is_div, last_iter, wr_en;
    logic [CW-1:0]      cnt;
    // acc holds {partial product, multiplier} for mul and {remainder, quotient} for udiv
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0]   opnd, mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   bb, wr_res, wr_rem;
    logic [WIDTH:0]     add_sum;
    logic               wr_c, wr_v;

    assign is_mul    = (ALUControl == 3'b101);
`ifdef ALU_MC_DIV_EN
    assign is_div    = (ALUControl == 3'b110);
`else
    assign is_div    = 1'b0;
`endif
    assign accept    = start & ready;
    assign last_iter = busy && (cnt == '0);
    assign wr_en     = (accept && !is_mul && !is_div) || last_iter;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (is_mul) state_nxt = S_MUL;
`ifdef ALU_MC_DIV_EN
                    else if (is_div) state_nxt = S_DIV;
`endif
                    else state_nxt = S_DONE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL: if (cnt == '0) state_nxt = S_DONE;
`ifdef ALU_MC_DIV_EN
            S_DIV: if (cnt == '0) state_nxt = S_DONE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_IDLE: ready = 1'b1;
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            S_MUL: busy = 1'b1;
`ifdef ALU_MC_DIV_EN
            S_DIV: busy = 1'b1;
`endif
            default: ;
        endcase
    end

    assign mul_addend = acc[0] ? opnd : '0;
    assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

`ifdef ALU_MC_DIV_EN
    logic [WIDTH:0] div_shift, div_diff;
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd};
`endif

    always_comb begin
        acc_nxt = {mul_sum, acc[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        // borrow out of the trial subtraction means restore the shifted remainder
        if (state == S_DIV)
            acc_nxt = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
`endif
    end

    always_comb begin
        bb      = (ALUControl == 3'b001) ? ~b : b;
        add_sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (ALUControl == 3'b001)};
        wr_res  = '0;
        wr_rem  = '0;
        wr_c    = 1'b0;
        wr_v    = 1'b0;
        if (state == S_MUL) begin
            wr_res = acc_nxt[WIDTH-1:0];
            wr_v   = |acc_nxt[2*WIDTH-1:WIDTH];
        end
`ifdef ALU_MC_DIV_EN
        else if (state == S_DIV) begin
            wr_rem = acc_nxt[2*WIDTH-1:WIDTH];
            if (opnd == '0) wr_v   = 1'b1;
            else            wr_res = acc_nxt[WIDTH-1:0];
        end
`endif
        else begin
            case (ALUControl)
                3'b000, 3'b001: begin
                    wr_res = add_sum[WIDTH-1:0];
                    wr_c   = add_sum[WIDTH];
                    wr_v   = (a[WIDTH-1] == bb[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
                end
                3'b010:  wr_res = a & b;
                3'b011:  wr_res = a | b;
                3'b111:  wr_res = a ^ b;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            opnd      <= '0;
            cnt       <= '0;
            Result    <= '0;
            Remainder <= '0;
            ALUFlags  <= '0;
        end else begin
            if (accept && is_mul) begin
                acc  <= {{WIDTH{1'b0}}, b};
                opnd <= a;
                cnt  <= CW'(WIDTH - 1);
            end else if (accept && is_div) begin
                acc  <= {{WIDTH{1'b0}}, a};
                opnd <= b;
                cnt  <= CW'(WIDTH - 1);
            end else if (busy) begin
                acc <= acc_nxt;
                cnt <= cnt - CW'(1);
            end
            if (wr_en) begin
                Result    <= wr_res;
                Remainder <= wr_rem;
                ALUFlags  <= {wr_res[WIDTH-1], (wr_res == '0), wr_c, wr_v};
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc with an arithmetic reference model.
module tb_alu_mc;

    localparam int W = 32;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));

    logic         clk, reset, start, busy, done;
    logic [W-1:0] a, b, Result, Remainder;
    logic [2:0]   ALUControl;
    logic [3:0]   ALUFlags;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] rm;
        logic [3:0]   f;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .ALUControl(ALUControl), .busy(busy), .done(done),
        .Result(Result), .Remainder(Remainder), .ALUFlags(ALUFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t           e;
        logic           c, v;
        longint         sx, sy, s;
        logic [W:0]     t;
        logic [2*W-1:0] p;
        e.r = '0; e.rm = '0; c = 1'b0; v = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            3'b000: begin
                t = {1'b0, x} + {1'b0, y};
                e.r = t[W-1:0]; c = t[W];
                s = sx + sy; v = (s > SMAX) || (s < SMIN);
            end
            3'b001: begin
                e.r = x - y; c = (x >= y);
                s = sx - sy; v = (s > SMAX) || (s < SMIN);
            end
            3'b010: e.r = x & y;
            3'b011: e.r = x | y;
            3'b111: e.r = x ^ y;
            3'b101: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.r = p[W-1:0]; v = (p[2*W-1:W] != '0);
            end
`ifdef ALU_MC_DIV_EN
            3'b110: begin
                if (y == '0) begin e.r = '0; e.rm = x; v = 1'b1; end
                else begin e.r = x / y; e.rm = x % y; end
            end
`endif
            default: ;
        endcase
        e.f = {e.r[W-1], (e.r == '0), c, v};
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            checks++; errors++;
            $display("FAIL issue_wait_ready busy stuck for %0d cycles", g);
        end
        a = x; b = y; ALUControl = op; start = 1'b1;
        exp_q.push_back(model(op, x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_latency(input string name, input int req);
        int lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check(name, lat, req);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done actual=1 required=0 Result=%0h", Result);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", Result, e.r);
                check("sb_remainder", Remainder, e.rm);
                check("sb_flags", ALUFlags, e.f);
            end
        end
    end

    initial begin
        int nb, lat, nd, g;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; ALUControl = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", Result, 0);
        check("reset_remainder", Remainder, 0);
        check("reset_flags", ALUFlags, 0);

        issue(3'b000, 32'h7FFF_FFFF, 32'h1);
        check("add_done_cycle1", done, 1);
        check("add_result", Result, 32'h8000_0000);
        check("add_flags", ALUFlags, 4'b1001);
        issue(3'b001, 32'd5, 32'd5);
        check("sub_flags", ALUFlags, 4'b0110);
        issue(3'b111, 32'hF0F0_F0F0, 32'hFFFF_0000);
        check("xor_b2b_done", done, 1);
        check("xor_result", Result, 32'h0F0F_F0F0);
        @(negedge clk);
        check("done_single_pulse", done, 0);

        issue(3'b101, 32'h0001_0000, 32'h0001_0001);
        lat = 1; nb = 0;
        while (!done && lat < 100) begin
            if (busy) nb++;
            if (lat == 5) begin
                start = 1'b1; ALUControl = 3'b000; a = 32'h1234; b = 32'h1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("mul_busy_cycles", nb, W);
        check("mul_latency", lat, W + 1);
        check("mul_result", Result, 32'h0001_0000);
        check("mul_overflow", ALUFlags[0], 1);

        issue(3'b110, 32'd100, 32'd7);
`ifdef ALU_MC_DIV_EN
        wait_latency("udiv_latency", W + 1);
        check("udiv_quotient", Result, 14);
        check("udiv_remainder", Remainder, 2);
`else
        wait_latency("op110_latency", 1);
        check("op110_result", Result, 0);
        check("op110_remainder", Remainder, 0);
        check("op110_flags", ALUFlags, 4'b0100);
`endif
        issue(3'b110, 32'd9, 32'd0);
`ifdef ALU_MC_DIV_EN
        wait_latency("udiv0_latency", W + 1);
        check("udiv0_remainder", Remainder, 9);
        check("udiv0_v", ALUFlags[0], 1);
`else
        wait_latency("op110_b0_latency", 1);
`endif
        @(negedge clk);

        issue(3'b101, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_result", Result, 0);
        check("rst_mid_remainder", Remainder, 0);
        check("rst_mid_flags", ALUFlags, 0);
        nd = 0;
        repeat (40) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("no_done_after_reset", nd, 0);
        issue(3'b000, 32'd3, 32'd4);
        check("add_after_reset_done", done, 1);
        check("add_after_reset_result", Result, 7);

        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        g = 0;
        while (exp_q.size() > 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
